// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, opcodes, flag indices and helpers shared by the CPU pipeline stages.
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int REG_AW = 4;
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_DEC  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_PASS = 4'hE;
    localparam logic [3:0] OP_RSVD = 4'hF;
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
    function automatic logic [2:0] make_flags(input logic [DATA_W-1:0] r, input logic c);
        make_flags = '0;
        make_flags[FLAG_Z] = r == '0;
        make_flags[FLAG_C] = c;
        make_flags[FLAG_N] = r[DATA_W-1];
    endfunction
endpackage

// File: rtl/mul8_seq.sv
// mul8_seq: shift-add multiplier, one partial product per cycle; product/done
// expose the value that the current step writes, so callers can capture it on the last edge.
module mul8_seq
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    logic [DATA_W-1:0]         a_r, b_r;
    logic [2*DATA_W-1:0]       acc;
    logic [$clog2(DATA_W)-1:0] cnt;

    assign product = b_r[cnt] ? acc + ({{DATA_W{1'b0}}, a_r} << cnt) : acc;
    assign done    = busy && cnt == ($clog2(DATA_W))'(MUL_CYCLES - 1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start && !busy) begin
            a_r  <= a;
            b_r  <= b;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc  <= product;
            cnt  <= cnt + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU plus sequential multiply, registered write-back
// strobe and {N,C,Z} flag register; stalls upstream while a multiply runs.
module execute_stage
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [3:0]        i_opcode,
    input  logic [REG_AW-1:0] i_destadd,
    input  logic [DATA_W-1:0] i_read_data1,
    input  logic [DATA_W-1:0] i_read_data2,
    output logic              o_write_en,
    output logic [REG_AW-1:0] o_write_reg,
    output logic [DATA_W-1:0] o_write_data,
    output logic [2:0]        o_flags,
    output logic              o_stall
);
    state_e              state, state_nx;
    logic                accept, is_mul, flag_en, wb_en, mul_busy, mul_done;
    logic [DATA_W:0]     r9;
    logic [2*DATA_W-1:0] mul_product;
    logic [REG_AW-1:0]   mul_dest;

    assign accept  = i_valid && !o_stall;
    assign is_mul  = i_opcode == OP_MUL;
    assign flag_en = !(i_opcode inside {OP_NOP, OP_RSVD, OP_MUL});
    assign wb_en   = flag_en && i_opcode != OP_CMP && i_destadd != '0;

    mul8_seq #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .start   (accept && is_mul),
        .a       (i_read_data1),
        .b       (i_read_data2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE) state_nx = accept && is_mul ? ST_BUSY : ST_IDLE;
        else                  state_nx = mul_done || !mul_busy ? ST_IDLE : ST_BUSY;
    end

    always_comb begin
        o_stall = state == ST_BUSY;
    end

    // Bit 8 of r9 doubles as the carry/borrow for every single-cycle op.
    always_comb begin
        r9 = '0;
        case (i_opcode)
            OP_ADD:         r9 = {1'b0, i_read_data1} + {1'b0, i_read_data2};
            OP_SUB, OP_CMP: r9 = {1'b0, i_read_data1} - {1'b0, i_read_data2};
            OP_AND:         r9 = {1'b0, i_read_data1 & i_read_data2};
            OP_OR:          r9 = {1'b0, i_read_data1 | i_read_data2};
            OP_XOR:         r9 = {1'b0, i_read_data1 ^ i_read_data2};
            OP_NOT:         r9 = {1'b0, ~i_read_data1};
            OP_SHL:         r9 = {i_read_data1, 1'b0};
            OP_SHR:         r9 = {i_read_data1[0], 1'b0, i_read_data1[DATA_W-1:1]};
            OP_MOV:         r9 = {1'b0, i_read_data1};
            OP_INC:         r9 = {1'b0, i_read_data1} + 9'd1;
            OP_DEC:         r9 = {1'b0, i_read_data1} - 9'd1;
            OP_PASS:        r9 = {1'b0, i_read_data2};
            default:        r9 = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_write_en   <= 1'b0;
            o_write_reg  <= '0;
            o_write_data <= '0;
            o_flags      <= '0;
            mul_dest     <= '0;
        end else begin
            o_write_en <= 1'b0;
            if (mul_done) begin
                o_write_en   <= mul_dest != '0;
                o_write_reg  <= mul_dest;
                o_write_data <= mul_product[DATA_W-1:0];
                o_flags      <= make_flags(mul_product[DATA_W-1:0], |mul_product[2*DATA_W-1:DATA_W]);
            end else if (accept) begin
                if (is_mul) mul_dest <= i_destadd;
                if (flag_en) o_flags <= make_flags(r9[DATA_W-1:0], r9[DATA_W]);
                if (wb_en) begin
                    o_write_en   <= 1'b1;
                    o_write_reg  <= i_destadd;
                    o_write_data <= r9[DATA_W-1:0];
                end
            end
        end
    end
endmodule
